// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares BRAM port 2 (read port plus single write port) between two masters.
// m0 is the core load/store unit and m1 is the debug/loader DMA. The arbiter issues at most one
// access per cycle. Responses come back one cycle after acceptance, which matches a synchronous
// BRAM read. A starvation guard limits how many grants in a row one master can take while the
// other master is waiting.
// Optional feature: define MEM_ARB_RR_EN to select round-robin tie-breaking. When it is undefined,
// arbitration is fixed priority with m0 above m1.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic                clk,
  input  logic                rst,
  // master 0
  input  logic                m0_req_valid,
  output logic                m0_req_ready,
  input  logic                m0_req_we,
  input  logic [ADDR_W-1:0]   m0_req_addr,
  input  logic [DATA_W-1:0]   m0_req_wdata,
  input  logic [DATA_W/8-1:0] m0_req_be,
  output logic                m0_resp_valid,
  output logic [DATA_W-1:0]   m0_resp_rdata,
  output logic                m0_resp_err,
  // master 1
  input  logic                m1_req_valid,
  output logic                m1_req_ready,
  input  logic                m1_req_we,
  input  logic [ADDR_W-1:0]   m1_req_addr,
  input  logic [DATA_W-1:0]   m1_req_wdata,
  input  logic [DATA_W/8-1:0] m1_req_be,
  output logic                m1_resp_valid,
  output logic [DATA_W-1:0]   m1_resp_rdata,
  output logic                m1_resp_err,
  // memory port 2
  output logic [ADDR_W-1:0]   mem_addr2,
  output logic                mem_wr_en,
  output logic [ADDR_W-1:0]   mem_wr_addr,
  output logic [DATA_W-1:0]   mem_wr_data,
  output logic [DATA_W/8-1:0] mem_byte_en,
  input  logic [DATA_W-1:0]   mem_rd_data2
);

  localparam int unsigned BeW  = DATA_W / 8;
  localparam int unsigned CntW = $clog2(MAX_BURST + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_BURST);

  logic            last_grant_q, last_grant_d;
  logic [CntW-1:0] burst_cnt_q, burst_cnt_d;
  logic            resp_pend_q, resp_pend_d;
  logic            resp_owner_q, resp_owner_d;
  logic            resp_we_q, resp_we_d;
  logic            resp_err_q, resp_err_d;

  logic              gnt_valid;
  logic              gnt_id;
  logic              loser_valid;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [BeW-1:0]    sel_be;
  logic              misaligned;
  logic              resp_live;
  logic [DATA_W-1:0] resp_rdata;

  // Pick one winner. Nothing is granted while reset is held, so every output stays 0 in reset.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = 1'b0;
    if (!rst) begin
      if (m0_req_valid && m1_req_valid) begin
        gnt_valid = 1'b1;
`ifdef MEM_ARB_RR_EN
        // Round-robin already alternates, so the burst guard never changes the result here.
        gnt_id = ~last_grant_q;
`else
        // m0 wins unless it has used up its burst allowance while m1 waits.
        gnt_id = (last_grant_q == 1'b0) && (burst_cnt_q == MaxCnt);
`endif
      end else if (m0_req_valid) begin
        gnt_valid = 1'b1;
        gnt_id    = 1'b0;
      end else if (m1_req_valid) begin
        gnt_valid = 1'b1;
        gnt_id    = 1'b1;
      end
    end
  end

  // Route the winning request's fields to the memory port.
  always_comb begin
    sel_we      = gnt_id ? m1_req_we    : m0_req_we;
    sel_addr    = gnt_id ? m1_req_addr  : m0_req_addr;
    sel_wdata   = gnt_id ? m1_req_wdata : m0_req_wdata;
    sel_be      = gnt_id ? m1_req_be    : m0_req_be;
    misaligned  = |sel_addr[1:0];
    loser_valid = gnt_id ? m0_req_valid : m1_req_valid;

    m0_req_ready = gnt_valid && !gnt_id;
    m1_req_ready = gnt_valid && gnt_id;

    mem_addr2   = '0;
    mem_wr_addr = '0;
    mem_wr_data = '0;
    mem_wr_en   = 1'b0;
    mem_byte_en = '0;
    if (gnt_valid) begin
      mem_addr2   = sel_addr;
      mem_wr_addr = sel_addr;
      mem_wr_data = sel_wdata;
      // A misaligned access is still accepted, but it never writes memory.
      if (sel_we && !misaligned) begin
        mem_wr_en   = 1'b1;
        mem_byte_en = sel_be;
      end
    end
  end

  // Next state for the burst counter, the last grant, and the one-deep response tracker.
  always_comb begin
    burst_cnt_d  = '0;
    last_grant_d = last_grant_q;
    if (gnt_valid) begin
      last_grant_d = gnt_id;
      if (loser_valid) begin
        if (gnt_id == last_grant_q) begin
          burst_cnt_d = (burst_cnt_q == MaxCnt) ? burst_cnt_q : burst_cnt_q + CntW'(1);
        end else begin
          burst_cnt_d = CntW'(1);
        end
      end
    end
    resp_pend_d  = gnt_valid;
    resp_owner_d = gnt_id;
    resp_we_d    = sel_we;
    resp_err_d   = misaligned;
  end

  // State registers, synchronous reset. Reset also drops any response still pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      burst_cnt_q  <= '0;
      resp_pend_q  <= 1'b0;
      resp_owner_q <= 1'b0;
      resp_we_q    <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      burst_cnt_q  <= burst_cnt_d;
      resp_pend_q  <= resp_pend_d;
      resp_owner_q <= resp_owner_d;
      resp_we_q    <= resp_we_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Steer the response to the master that owns it. Read data passes through only for good reads.
  always_comb begin
    resp_live  = resp_pend_q && !rst;
    resp_rdata = (resp_live && !resp_we_q && !resp_err_q) ? mem_rd_data2 : '0;

    m0_resp_valid = resp_live && !resp_owner_q;
    m1_resp_valid = resp_live && resp_owner_q;
    m0_resp_err   = m0_resp_valid && resp_err_q;
    m1_resp_err   = m1_resp_valid && resp_err_q;
    m0_resp_rdata = resp_owner_q ? '0 : resp_rdata;
    m1_resp_rdata = resp_owner_q ? resp_rdata : '0;
  end

endmodule
